// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Multi-cycle multiply/divide sequencer that owns the architectural HI/LO
// registers. MULT/MULTU run for a fixed MUL_LAT busy cycles. DIV/DIVU run a
// 32-iteration restoring divide on operand magnitudes, followed by one FIX
// cycle that applies the result signs. A zero divisor completes after one busy
// cycle and leaves HI/LO untouched. MTHI/MTLO writes are accepted only while
// idle with no start pending. A flush aborts whatever is in flight, with no
// HI/LO update and no done pulse.
//
// Ports:
//   clk_i         clock; all state updates on the rising edge
//   reset_i       synchronous active-high reset
//   start_i       issue request, sampled only in IDLE
//   op_i          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a_i       rs operand (dividend / multiplicand)
//   src_b_i       rt operand (divisor / multiplier)
//   hilo_wen_i    bit1 writes HI, bit0 writes LO (MTHI/MTLO)
//   hilo_wdata_i  write data for hilo_wen_i
//   flush_i       abort the in-flight operation
//   busy_o        high whenever the sequencer is not idle
//   done_o        one-cycle pulse, new HI/LO visible this cycle
//   hi_o, lo_o    architectural HI / LO registers
//
// Parameter:
//   MUL_LAT       multiply busy cycles, legal range 1..8
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [1:0]  hilo_wen_i,
    input  logic [31:0] hilo_wdata_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DZ   = 3'd4
    } state_e;

    // The MUL counter is loaded with MUL_LAT-1 so that it leaves MUL after
    // exactly MUL_LAT cycles.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            mag32 = 32'd0 - v;
        end else begin
            mag32 = v;
        end
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        if (neg) begin
            cond_neg32 = 32'd0 - v;
        end else begin
            cond_neg32 = v;
        end
    endfunction

    state_e      state_q;
    logic [5:0]  cnt_q;
    // Multiply: opa_q/opb_q hold the raw operands.
    // Divide:   opa_q is the dividend/quotient shift register, opb_q the
    //           divisor magnitude, rem_q the partial remainder.
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] rem_q;
    logic        sgn_mul_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic [63:0] ext_a_d;
    logic [63:0] ext_b_d;
    logic [63:0] prod_d;
    logic [32:0] shifted_d;
    logic        fits_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix_d;
    logic [31:0] rem_fix_d;
    logic        start_sgn_d;
    logic [31:0] a_mag_d;
    logic [31:0] b_mag_d;

    // 64-bit product of the latched operands. Extending both operands to 64
    // bits (sign- or zero-) and keeping the low 64 bits of the product gives
    // the correct signed or unsigned result.
    always_comb begin
        if (sgn_mul_q) begin
            ext_a_d = {{32{opa_q[31]}}, opa_q};
            ext_b_d = {{32{opb_q[31]}}, opb_q};
        end else begin
            ext_a_d = {32'd0, opa_q};
            ext_b_d = {32'd0, opb_q};
        end
        prod_d = ext_a_d * ext_b_d;
    end

    // One restoring-division step: shift in the next dividend bit, then
    // subtract the divisor if it fits. The partial remainder is always below
    // the divisor, so the difference fits back into 32 bits.
    always_comb begin
        shifted_d = {rem_q, opa_q[31]};
        fits_d    = (shifted_d >= {1'b0, opb_q});
        if (fits_d) begin
            rem_d = shifted_d[31:0] - opb_q;
        end else begin
            rem_d = shifted_d[31:0];
        end
        quo_d = {opa_q[30:0], fits_d};
    end

    // Sign fix-up: the quotient is negative when the operand signs differ,
    // and the remainder takes the dividend's sign (truncation toward zero).
    always_comb begin
        quo_fix_d = cond_neg32(opa_q, neg_quo_q);
        rem_fix_d = cond_neg32(rem_q, neg_rem_q);
    end

    // Operand preparation for an accepted start (op_i[0]=0 means signed).
    always_comb begin
        start_sgn_d = ~op_i[0];
        a_mag_d     = mag32(src_a_i, start_sgn_d);
        b_mag_d     = mag32(src_b_i, start_sgn_d);
    end

    // Sequencer FSM together with the HI/LO registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            rem_q     <= 32'd0;
            sgn_mul_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        // Flush beats both start and HI/LO writes.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (start_i) begin
                        busy_q <= 1'b1;
                        if (!op_i[1]) begin
                            state_q   <= S_MUL;
                            cnt_q     <= MUL_LOAD;
                            opa_q     <= src_a_i;
                            opb_q     <= src_b_i;
                            sgn_mul_q <= start_sgn_d;
                        end else if (src_b_i == 32'd0) begin
                            state_q <= S_DZ;
                        end else begin
                            state_q   <= S_DIV;
                            cnt_q     <= 6'd0;
                            opa_q     <= a_mag_d;
                            opb_q     <= b_mag_d;
                            rem_q     <= 32'd0;
                            neg_quo_q <= start_sgn_d & (src_a_i[31] ^ src_b_i[31]);
                            neg_rem_q <= start_sgn_d & src_a_i[31];
                        end
                    end else begin
                        // MTHI/MTLO: each half written independently.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (hilo_wen_i[1]) begin
                            hi_q <= hilo_wdata_i;
                        end else begin
                            hi_q <= hi_q;
                        end
                        if (hilo_wen_i[0]) begin
                            lo_q <= hilo_wdata_i;
                        end else begin
                            lo_q <= lo_q;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 6'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        opa_q <= quo_d;
                        if (cnt_q == DIV_LAST) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!flush_i) begin
                        done_q <= 1'b1;
                        lo_q   <= quo_fix_d;
                        hi_q   <= rem_fix_d;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                S_DZ: begin
                    // Divide by zero: HI/LO are left as they were.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= ~flush_i;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [1:0]  hilo_wen = 2'b00;
    logic [31:0] hilo_wdata = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cyc;
    } exp_t;
    exp_t sb[$];

    hilo_muldiv_ctrl #(.MUL_LAT(3)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .op_i         (op),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .hilo_wen_i   (hilo_wen),
        .hilo_wdata_i (hilo_wdata),
        .flush_i      (flush),
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected completion.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with hi=%h lo=%h, no completion expected",
                         cyc, hi, lo);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (hi !== e.hi || lo !== e.lo || 32'(cyc) !== e.cyc) begin
                    miscompares++;
                    $display("FAIL done_result: got hi=%h lo=%h cycle=%0d, expected hi=%h lo=%h cycle=%0d",
                             hi, lo, cyc, e.hi, e.lo, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Issue one op in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                         input bit push);
        op        = o;
        src_a     = a;
        src_b     = b;
        start     = 1'b1;
        start_cyc = cyc;
        if (push) sb.push_back(exp_t'{ehi, elo, 32'(start_cyc + lat)});
        tick();
        start    = 1'b0;
        hilo_wen = 2'b00;
        src_a    = 32'hDEADBEEF;
        src_b    = 32'h0000_0000;
        chk("busy_cycle1", 32'(busy), 32'd1);
    endtask

    // Wait for busy to drop and check in which cycle it did.
    task automatic wait_idle(input string name, input int lat);
        int n = 0;
        while (busy && n < 80) begin
            tick();
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles", name, n);
        end else begin
            chk(name, 32'(cyc - start_cyc), 32'(lat));
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int lat);
        issue(o, a, b, ehi, elo, lat, 1'b1);
        wait_idle(name, lat);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Multiplies.
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 4, 1'b1);
        start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd5;
        tick();
        start = 1'b0;
        wait_idle("mult_b2b", 4);
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFA;
        run_op("mult_maxpos", OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 4);
        run_op("mult_minneg", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 4);
        run_op("mult_m1m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4);

        // Divides.
        run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34);
        run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 34);

        // MTHI / MTLO, then divide by zero keeps them.
        hilo_wen = 2'b10; hilo_wdata = 32'h11;
        tick();
        hilo_wen = 2'b01; hilo_wdata = 32'h22;
        tick();
        hilo_wen = 2'b00;
        exp_hi = 32'h11; exp_lo = 32'h22;
        chk("mthi", hi, exp_hi);
        chk("mtlo", lo, exp_lo);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 2);

        // Flush in cycle 10 of a divide, then MTHI in the next idle cycle.
        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 34, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush10_busy", 32'(busy), 32'd0);
        chk("flush10_done", 32'(done), 32'd0);
        chk("flush10_hi", hi, exp_hi);
        chk("flush10_lo", lo, exp_lo);
        hilo_wen = 2'b10; hilo_wdata = 32'h0000ABCD;
        tick();
        hilo_wen = 2'b00;
        exp_hi = 32'h0000ABCD;
        chk("mthi_after_flush_hi", hi, exp_hi);
        chk("mthi_after_flush_lo", lo, exp_lo);

        // Start and write in the same idle cycle: start wins.
        hilo_wen = 2'b01; hilo_wdata = 32'h0000DEAD;
        run_op("start_beats_wen", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 4);

        // Write while busy is ignored.
        issue(OP_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 4, 1'b1);
        hilo_wen = 2'b11; hilo_wdata = 32'h5555;
        tick();
        hilo_wen = 2'b00;
        wait_idle("wen_while_busy", 4);
        exp_hi = 32'd0; exp_lo = 32'd63;

        // Flush together with start and write in idle.
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd3;
        flush = 1'b1; hilo_wen = 2'b11; hilo_wdata = 32'h77;
        tick();
        start = 1'b0; flush = 1'b0; hilo_wen = 2'b00;
        chk("flush_idle_busy", 32'(busy), 32'd0);
        chk("flush_idle_hi", hi, exp_hi);
        chk("flush_idle_lo", lo, exp_lo);
        tick();
        chk("flush_idle_busy2", 32'(busy), 32'd0);

        // Flush in the final multiply cycle.
        issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 4, 1'b0);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_mul_busy", 32'(busy), 32'd0);
        chk("flush_mul_done", 32'(done), 32'd0);
        chk("flush_mul_lo", lo, exp_lo);

        // Flush during FIX.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 34, 1'b0);
        repeat (32) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_fix_busy", 32'(busy), 32'd0);
        chk("flush_fix_done", 32'(done), 32'd0);
        chk("flush_fix_hi", hi, exp_hi);
        chk("flush_fix_lo", lo, exp_lo);
        repeat (2) tick();

        // Reset in cycle 20 of a divide.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 34, 1'b0);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        run_op("mul_after_rst", OP_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 4);

        repeat (4) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS core. It accepts MULT/MULTU/DIV/DIVU issued from execute, runs a fixed-latency multiply or a 32-iteration restoring divide, and asserts busy so the pipeline stalls. It also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.

Parameters:
MUL_LAT, 3, busy cycles for a multiply; legal range 1..8.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
start  in  1  issue request; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  32  rs operand (dividend / multiplicand)
src_b  in  32  rt operand (divisor / multiplier)
hilo_wen  in  2  bit1 write HI, bit0 write LO (MTHI/MTLO)
hilo_wdata  in  32  data for hilo_wen
flush  in  1  abort in-flight op (exception/eret)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse: new HI/LO visible this cycle
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, internal counters/operands cleared. Reset mid-operation discards the op.
- States: IDLE, MUL, DIV, FIX, DZ.
- Start accepted in cycle 0 when state=IDLE, start=1, flush=0: src_a, src_b, op latched; later operand changes are ignored.
- IDLE->MUL for op[1]=0. MUL holds MUL_LAT cycles (down-counter); product computed on latched operands, signed for MULT, unsigned for MULTU. hi/lo={hi,lo}=64-bit product at the edge leaving MUL. Busy cycles 1..MUL_LAT; done=1 and busy=0 in cycle MUL_LAT+1.
- IDLE->DZ when op[1]=1 and src_b=0: one busy cycle, hi/lo unchanged, done=1 in cycle 2.
- IDLE->DIV otherwise: operands converted to magnitudes (DIV: two's-complement abs; DIVU: as is), 32 restoring iterations (1 quotient bit/cycle, MSB first, 6-bit counter), then FIX for 1 cycle. DIV: quotient negated if signs differ; remainder takes the dividend's sign (truncate toward zero). lo=quotient, hi=remainder, written at the edge leaving FIX. Busy cycles 1..33, done cycle 34.
- 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0; no trap.
- done: registered, exactly one cycle, never asserted without a hi/lo-update state completing (DZ included).
- start while busy: ignored (no queueing); pipeline stalls on busy.
- hilo_wen: applied at clock edge only when state=IDLE and start=0; each bit independent. Ignored while busy. start and hilo_wen in the same IDLE cycle: start wins, write dropped.
- flush: any cycle it is high, next state=IDLE, no hi/lo update, no done; takes priority over start, over completion in the final busy cycle, and over hilo_wen.
- hi/lo outputs are the registers directly (no bypass of an in-flight result).

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_LAT=3 -> busy cycles 1-3; cycle 4: done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFE x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Back-to-back start in cycle 1 is ignored; hi/lo reflect only the first op.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> done in cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 with hi=0x11, lo=0x22 -> done in cycle 2, hi/lo unchanged.
- DIV 100/7 with flush in cycle 10 -> busy=0 in cycle 11, no done, hi/lo unchanged. MTHI 0xABCD in the next IDLE cycle -> hi=0xABCD, lo unchanged.
- Reset asserted in cycle 20 of a divide -> next cycle hi=lo=0, busy=0, done=0. Flush during the final FIX cycle -> no update.
